// File: rtl/load_align_sequencer_if.sv
// rtl/load_align_sequencer_if.sv - load type package and load/memory handshake interface
//
// load_align_pkg: truncType, the load size/sign code shared with the writeback truncator.
// load_align_sequencer_if: groups the load request, memory read and truncator result signals.
//   slave  : sequencer view (LoadReq/LoadAddr/LoadType/MemAck/MemRData in,
//            ReqReady/MemReq/MemAddr/LoadDone/LoadData/TruncSrc/TruncTypeOut/LoadMisaligned out)
//   master : pipeline/memory view, directions reversed.
// XLEN is taken from the `XLEN macro (32 when not defined).

`ifndef XLEN
`define XLEN 32
`endif

package load_align_pkg;
  typedef enum logic [2:0] {
    NO_TRUNC           = 3'd0,
    BYTE               = 3'd1,
    HALF_WORD          = 3'd2,
    WORD               = 3'd3,
    BYTE_UNSIGNED      = 3'd4,
    HALF_WORD_UNSIGNED = 3'd5,
    WORD_UNSIGNED      = 3'd6
  } truncType;
endpackage

interface load_align_sequencer_if;
  import load_align_pkg::*;

  localparam int XLEN = `XLEN;
  localparam int NB   = XLEN / 8;
  localparam int OW   = $clog2(NB);

  logic            LoadReq;
  logic [XLEN-1:0] LoadAddr;
  truncType        LoadType;
  logic            ReqReady;
  logic            MemReq;
  logic [XLEN-1:0] MemAddr;
  logic            MemAck;
  logic [XLEN-1:0] MemRData;
  logic            LoadDone;
  logic [XLEN-1:0] LoadData;
  logic [OW-1:0]   TruncSrc;
  truncType        TruncTypeOut;
  logic            LoadMisaligned;

  modport slave (
    input  LoadReq, LoadAddr, LoadType, MemAck, MemRData,
    output ReqReady, MemReq, MemAddr, LoadDone, LoadData, TruncSrc, TruncTypeOut, LoadMisaligned
  );

  modport master (
    output LoadReq, LoadAddr, LoadType, MemAck, MemRData,
    input  ReqReady, MemReq, MemAddr, LoadDone, LoadData, TruncSrc, TruncTypeOut, LoadMisaligned
  );
endinterface

// File: rtl/load_align_sequencer.sv
// rtl/load_align_sequencer.sv - memory-stage load sequencer with boundary-split merge
//
// Issues aligned data-memory reads for a load and hands the truncator its input word.
// Contained loads: one read, LoadData = raw word, TruncSrc = byte offset.
// Straddling loads (offset + size > NB): two aligned reads merged so the requested
// bytes start at byte 0, TruncSrc = 0.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : load_align_sequencer_if.slave (request, memory read, truncator result)
// Optional feature macro MISALIGNED_SPLIT_EN: when defined, straddling loads are split;
// when undefined they complete immediately with LoadMisaligned=1 and no memory access.

`ifndef XLEN
`define XLEN 32
`endif

module load_align_sequencer
  import load_align_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  load_align_sequencer_if.slave  bus
);

  localparam int XLEN = `XLEN;
  localparam int NB   = XLEN / 8;
  localparam int OW   = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ1, S_REQ2, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  truncType        type_q, type_d;
  logic            split_q, split_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [OW-1:0]   src_q, src_d;
  truncType        tto_q, tto_d;
  logic            mis_q, mis_d;

  logic [OW:0]       req_size;
  logic              req_split;
  logic [XLEN-1:0]   base;
  logic [2*XLEN-1:0] pair;
  logic [2*XLEN-1:0] merged;

  function automatic logic [OW:0] size_of(input truncType t);
    logic [OW:0] s;
    case (t)
      BYTE, BYTE_UNSIGNED:          s = (OW+1)'(1);
      HALF_WORD, HALF_WORD_UNSIGNED: s = (OW+1)'(2);
      WORD, WORD_UNSIGNED:          s = (OW+1)'(4);
      default:                      s = (OW+1)'(NB);
    endcase
    return s;
  endfunction

  // Sum is one bit wider than the offset so NB itself is representable.
  assign req_size  = size_of(bus.LoadType);
  assign req_split = ({1'b0, bus.LoadAddr[OW-1:0]} + req_size) > (OW+1)'(NB);

  assign base   = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  // Hi word arrives on MemRData during the REQ2 ack; shift drops the leading offset bytes.
  assign pair   = {bus.MemRData, lo_q};
  assign merged = pair >> {addr_q[OW-1:0], 3'b000};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    type_d  = type_q;
    split_d = split_q;
    lo_d    = lo_q;
    data_d  = data_q;
    src_d   = src_q;
    tto_d   = tto_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (bus.LoadReq) begin
          addr_d  = bus.LoadAddr;
          type_d  = bus.LoadType;
          split_d = req_split;
          mis_d   = 1'b0;
          state_d = S_REQ1;
`ifndef MISALIGNED_SPLIT_EN
          if (req_split) begin
            data_d  = '0;
            src_d   = '0;
            tto_d   = NO_TRUNC;
            mis_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_REQ1: begin
        if (bus.MemAck) begin
          lo_d = bus.MemRData;
          if (split_q) begin
            state_d = S_REQ2;
          end else begin
            data_d  = bus.MemRData;
            src_d   = addr_q[OW-1:0];
            tto_d   = type_q;
            state_d = S_DONE;
          end
        end
      end
      S_REQ2: begin
        if (bus.MemAck) begin
          data_d  = merged[XLEN-1:0];
          src_d   = '0;
          tto_d   = type_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      type_q  <= NO_TRUNC;
      split_q <= 1'b0;
      lo_q    <= '0;
      data_q  <= '0;
      src_q   <= '0;
      tto_q   <= NO_TRUNC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      split_q <= split_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      src_q   <= src_d;
      tto_q   <= tto_d;
      mis_q   <= mis_d;
    end
  end

  // Second access address wraps modulo 2^XLEN.
  assign bus.ReqReady       = (state_q == S_IDLE);
  assign bus.MemReq         = (state_q == S_REQ1) || (state_q == S_REQ2);
  assign bus.MemAddr        = (state_q == S_REQ1) ? base :
                              (state_q == S_REQ2) ? (base + XLEN'(NB)) : '0;
  assign bus.LoadDone       = (state_q == S_DONE);
  assign bus.LoadData       = data_q;
  assign bus.TruncSrc       = src_q;
  assign bus.TruncTypeOut   = tto_q;
  assign bus.LoadMisaligned = (state_q == S_DONE) && mis_q;

endmodule

// File: doc/load_align_sequencer.md
Name: load_align_sequencer

Overview:
Memory-stage controller that sequences data-memory reads for loads and produces the word consumed by the writeback truncator. Aligned or contained loads take one memory access, and the truncator receives the raw word plus the byte offset. Loads that straddle an XLEN/8 boundary are split into two aligned accesses and merged so the requested bytes start at offset 0. The block drives TruncSrc/TruncType toward writeback and exposes a ready/done handshake to the pipeline stall logic.

Parameters:
XLEN, `XLEN (32 or 64), datapath width.
NB, XLEN/8, bytes per memory word.
OW, $clog2(NB), width of the byte offset.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
LoadReq  in  1  load request from memory stage
LoadAddr  in  XLEN  byte address of load
LoadType  in  truncType  HighLevelControl load size/sign
ReqReady  out  1  block idle, request accepted this cycle if LoadReq
MemReq  out  1  memory read request
MemAddr  out  XLEN  aligned (low OW bits zero) read address
MemAck  in  1  memory read data valid this cycle
MemRData  in  XLEN  memory read data
LoadDone  out  1  one-cycle pulse, outputs below valid
LoadData  out  XLEN  word for the truncator InputData
TruncSrc  out  OW  byte offset for the truncator
TruncTypeOut  out  truncType  type for the truncator
LoadMisaligned  out  1  misaligned-load exception pulse, qualified by LoadDone

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset: state=IDLE. MemReq=0, MemAddr=0, LoadDone=0, LoadData=0, TruncSrc=0, TruncTypeOut=NO_TRUNC, LoadMisaligned=0. All outputs are registered or decoded only from registered state.
- Size decode: BYTE/BYTE_UNSIGNED=1, HALF_WORD/HALF_WORD_UNSIGNED=2, WORD=4, WORD_UNSIGNED=4 (XLEN_64 only), NO_TRUNC=NB.
- Split condition: off+size>NB, where off=LoadAddr[OW-1:0]. Compute the sum OW+1 bits wide.
- States:
  - IDLE: ReqReady=1. On LoadReq, latch the address, type and split flag, then go to REQ1.
  - REQ1: MemReq=1, MemAddr=base (addr with low OW bits cleared). On MemAck, capture Lo=MemRData. If split, go to REQ2; otherwise go to DONE.
  - REQ2: MemReq=1, MemAddr=base+NB, modulo 2^XLEN, so it wraps to 0. On MemAck, capture Hi and go to DONE.
  - DONE: LoadDone=1 for one cycle, then return to IDLE.
    - Non-split: LoadData=Lo, TruncSrc=off.
    - Split: LoadData=low XLEN bits of ({Hi,Lo}>>(off*8)), TruncSrc=0.
    - TruncTypeOut=latched type in both cases.
- MemReq and MemAddr stay stable until MemAck. MemAck outside REQ1/REQ2 is ignored.
- Latency: accept at cycle N, so MemReq is first seen at N+1. LoadDone occurs the cycle after the final MemAck. Minimum latency is 2 cycles (single access) or 3 cycles (split).
- LoadReq is ignored while ReqReady=0. The requester holds LoadReq until accepted.
- Reset mid-operation (any state) forces IDLE next cycle. MemReq drops, no LoadDone is issued, and a late MemAck is ignored.
- Between loads, LoadData, TruncSrc and TruncTypeOut hold their last values.

Optional Feature:
MISALIGNED_SPLIT_EN
- Defined: split loads are handled as above. LoadMisaligned is tied 0.
- Undefined: a request meeting the split condition goes IDLE→DONE without any MemReq. DONE asserts LoadDone=1 and LoadMisaligned=1, with LoadData=0 and TruncTypeOut=NO_TRUNC. Non-split loads are unchanged and REQ2 is unreachable.

Test Plan:
1. XLEN=32, LW 0x100, MemAck at N+1 with 0xDEADBEEF → exactly one MemReq (addr 0x100). LoadDone at N+2 with LoadData=0xDEADBEEF, TruncSrc=0, TruncTypeOut=WORD.
2. LBU 0x103, data 0x44332211 → single access at addr 0x100. LoadData=0x44332211, TruncSrc=3.
3. LW 0x102, with 0x100→0x44332211 and 0x104→0x88776655 → two MemReqs (0x100, 0x104). LoadData=0x66554433, TruncSrc=0, LoadMisaligned=0.
4. LH 0x103 with the same memory, MemAck delayed 3 cycles on each access → MemAddr held stable while waiting. LoadData=0x77665544, TruncSrc=0, and exactly one LoadDone.
5. LW 0xFFFFFFFE → second MemAddr=0x00000000. Separately, reset asserted during REQ2 → MemReq=0 and ReqReady=1 next cycle, no LoadDone, and a subsequent stray MemAck is ignored.
6. Build without MISALIGNED_SPLIT_EN, LW 0x102 → no MemReq. LoadDone=1 and LoadMisaligned=1 one cycle after accept. A following aligned LW completes normally.
